// File: rtl/disp_scan_pkg.sv
// Shared constants for the multiplexed seven-segment scanner.
// Also used by disp_scan_if and disp_scan (the LEADING_ZERO_BLANK_EN option lives in disp_scan.sv).
package disp_scan_pkg;

  localparam int DIGITS_DEF = 8;

  // Wide enough to index the largest legal digit count (8).
  localparam int IDX_W = 3;

  // Active-low anodes: every digit off.
  localparam logic [7:0] AN_ALL_OFF = 8'hFF;

endpackage

// File: rtl/disp_scan_if.sv
// Load/display bundle between a display-word producer (master) and disp_scan (slave).
interface disp_scan_if
  import disp_scan_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF
);

  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   digit_en;
  logic                load;
  logic                load_ack;
  logic [3:0]          nibble;
  logic [DIGITS-1:0]   an;
  logic                blank;
  logic                frame_start;

  modport master (
    output value, digit_en, load,
    input  load_ack, nibble, an, blank, frame_start
  );

  modport slave (
    input  value, digit_en, load,
    output load_ack, nibble, an, blank, frame_start
  );

endinterface

// File: rtl/scan_prescaler.sv
// Free-running divider: tick is high for one clock out of every DIV_MAX+1.
module scan_prescaler #(
  parameter int DIV_MAX = 99999
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CNT_W = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CNT_W'(DIV_MAX));
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/disp_scan.sv
// Time-multiplexed display scanner with double-buffered display word, swapped at frame end.
// Define LEADING_ZERO_BLANK_EN to darken leading zero digits (digit 0 always stays lit).
module disp_scan
  import disp_scan_pkg::*;
#(
  parameter int DIV_MAX = 99999,
  parameter int DIGITS  = DIGITS_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  disp_scan_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic                tick;
  logic                boundary;
  logic                capture;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] stg_val_q, stg_val_d;
  logic [DIGITS-1:0]   stg_en_q, stg_en_d;
  logic [4*DIGITS-1:0] shd_val_q, shd_val_d;
  logic [DIGITS-1:0]   shd_en_q, shd_en_d;
  logic                pend_q, pend_d;
  logic [3:0]          nibble_q, nibble_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                blank_q, blank_d;
  logic                load_ack_q, load_ack_d;
  logic                frame_start_q, frame_start_d;
  logic [DIGITS-1:0]   lz_blank;
  logic                lit;

  scan_prescaler #(.DIV_MAX(DIV_MAX)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    idx_d         = idx_q;
    stg_val_d     = stg_val_q;
    stg_en_d      = stg_en_q;
    shd_val_d     = shd_val_q;
    shd_en_d      = shd_en_q;
    pend_d        = pend_q;
    load_ack_d    = 1'b0;
    boundary      = tick && (idx_q == LAST_IDX);
    capture       = boundary && (pend_q || bus.load);
    frame_start_d = boundary;

    if (tick) idx_d = boundary ? '0 : idx_q + 1'b1;

    // A load landing on the swap cycle bypasses staging straight into the shadow.
    if (capture) begin
      shd_val_d  = bus.load ? bus.value    : stg_val_q;
      shd_en_d   = bus.load ? bus.digit_en : stg_en_q;
      pend_d     = 1'b0;
      load_ack_d = 1'b1;
    end else if (bus.load) begin
      stg_val_d = bus.value;
      stg_en_d  = bus.digit_en;
      pend_d    = 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic zero_run;

  // Walk down from the top digit; blank while everything seen so far is zero.
  always_comb begin
    zero_run = 1'b1;
    lz_blank = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (shd_val_d[4*i +: 4] == 4'h0);
      if (i != 0) lz_blank[i] = zero_run;
    end
  end
`else
  assign lz_blank = '0;
`endif

  // Outputs are built from next-state values so they line up with the new index.
  always_comb begin
    nibble_d = 4'h0;
    lit      = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        nibble_d = shd_val_d[4*i +: 4];
        lit      = shd_en_d[i] && !lz_blank[i];
      end
    end
    an_d    = lit ? ~(DIGITS'(1) << idx_d) : AN_ALL_OFF[DIGITS-1:0];
    blank_d = !lit;
  end

  // NOTE: state uses non-blocking assignments so all flops update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: staging and shadow are plain registers and are cleared, so a reset also discards pending data.
      idx_q         <= '0;
      stg_val_q     <= '0;
      stg_en_q      <= '0;
      shd_val_q     <= '0;
      shd_en_q      <= '0;
      pend_q        <= 1'b0;
      nibble_q      <= 4'h0;
      an_q          <= AN_ALL_OFF[DIGITS-1:0];
      blank_q       <= 1'b1;
      load_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      idx_q         <= idx_d;
      stg_val_q     <= stg_val_d;
      stg_en_q      <= stg_en_d;
      shd_val_q     <= shd_val_d;
      shd_en_q      <= shd_en_d;
      pend_q        <= pend_d;
      nibble_q      <= nibble_d;
      an_q          <= an_d;
      blank_q       <= blank_d;
      load_ack_q    <= load_ack_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.nibble      = nibble_q;
  assign bus.an          = an_q;
  assign bus.blank       = blank_q;
  assign bus.load_ack    = load_ack_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_disp_scan.sv
// Directed and random checks of disp_scan (DIV_MAX=3, DIGITS=8) against a frame-level model.
module tb_disp_scan;

  localparam int DIV = 3;
  localparam int DIG = 8;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  disp_scan_if #(.DIGITS(DIG)) bus ();

  disp_scan #(.DIV_MAX(DIV), .DIGITS(DIG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: cycles since reset, digit position, displayed and staged words.
  int          m_cyc;
  int          m_idx;
  logic [31:0] m_sh_val, m_stg_val;
  logic [7:0]  m_sh_en, m_stg_en;
  bit          m_pend, m_ack, m_fs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model across the edge, then compare all outputs.
  task automatic step(input bit ld, input logic [31:0] v, input logic [7:0] e, input bit rst);
    bit          tick, bnd, lit;
    logic [31:0] upper;
    logic [7:0]  exp_an;
    bus.load     = ld;
    bus.value    = v;
    bus.digit_en = e;
    rst_n        = !rst;
    @(posedge clk);
    if (rst) begin
      m_cyc = 0; m_idx = 0; m_sh_val = '0; m_stg_val = '0;
      m_sh_en = '0; m_stg_en = '0; m_pend = 0; m_ack = 0; m_fs = 0;
    end else begin
      tick  = (m_cyc % (DIV + 1)) == DIV;
      m_cyc++;
      bnd   = tick && (m_idx == DIG - 1);
      m_ack = 0;
      m_fs  = bnd;
      if (bnd && (m_pend || ld)) begin
        m_sh_val = ld ? v : m_stg_val;
        m_sh_en  = ld ? e : m_stg_en;
        m_pend   = 0;
        m_ack    = 1;
      end else if (ld) begin
        m_stg_val = v;
        m_stg_en  = e;
        m_pend    = 1;
      end
      if (tick) m_idx = (m_idx + 1) % DIG;
    end
    #1;
    upper  = m_sh_val >> (4 * m_idx);
    lit    = m_sh_en[m_idx] && !(LZB && m_idx > 0 && upper == 0);
    exp_an = lit ? ~(8'h01 << m_idx) : 8'hFF;
    check("nibble", bus.nibble, upper & 32'hF);
    check("an", bus.an, exp_an);
    check("blank", bus.blank, !lit);
    check("load_ack", bus.load_ack, m_ack);
    check("frame_start", bus.frame_start, m_fs);
    bus.load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0);
  endtask

  // Run until load_ack (bounded); leaves the bench at the first idx-0 cycle of the new frame.
  task automatic wait_ack(input string tag);
    int n   = 0;
    bit got = 0;
    while (!got && n < 40) begin
      step(0, '0, '0, 0);
      n++;
      got = bus.load_ack;
    end
    check(tag, got, 1);
  endtask

  logic [31:0] word;
  logic [7:0]  exp_an8;
  int          lit_cnt, extra_acks, n;
  bit          seen;

  initial begin
    bus.load = 0; bus.value = '0; bus.digit_en = '0; rst_n = 0;

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) step(0, '0, '0, 1);
    check("rst_an", bus.an, 8'hFF);
    check("rst_nibble", bus.nibble, 0);
    check("rst_blank", bus.blank, 1);
    check("rst_ack", bus.load_ack, 0);
    check("rst_fs", bus.frame_start, 0);

    // Basic scan of 12345678.
    word = 32'h12345678;
    step(1, word, 8'hFF, 0);
    wait_ack("scan_ack");
    check("scan_nib0", bus.nibble, 8);
    check("scan_an0", bus.an, 8'hFE);
    for (int d = 1; d < DIG; d++) begin
      idle(DIV + 1);
      exp_an8 = ~(8'h01 << d);
      check("scan_nib", bus.nibble, (word >> (4 * d)) & 32'hF);
      check("scan_an", bus.an, exp_an8);
    end

    // Two loads before one boundary: the second wins, with a single ack.
    step(1, 32'h11111111, 8'hFF, 0);
    step(1, 32'h22222222, 8'hFF, 0);
    wait_ack("latest_ack");
    extra_acks = 0;
    for (int d = 0; d < DIG; d++) begin
      if (d > 0) begin
        for (int i = 0; i <= DIV; i++) begin
          step(0, '0, '0, 0);
          if (bus.load_ack) extra_acks++;
        end
      end
      check("latest_nib", bus.nibble, 2);
    end
    check("latest_single_ack", extra_acks, 0);

    // Enable mask: upper four digits dark.
    step(1, 32'h87654321, 8'h0F, 0);
    wait_ack("mask_ack");
    for (int d = 0; d < DIG; d++) begin
      if (d > 0) idle(DIV + 1);
      exp_an8 = (d < 4) ? ~(8'h01 << d) : 8'hFF;
      check("mask_an", bus.an, exp_an8);
      check("mask_blank", bus.blank, d >= 4);
    end

    // Leading-zero blanking (or its absence).
    step(1, 32'h000000A0, 8'hFF, 0);
    wait_ack("lzb_ack");
    lit_cnt = 0;
    for (int d = 0; d < DIG; d++) begin
      if (d > 0) idle(DIV + 1);
      if (!bus.blank) lit_cnt++;
      if (d == 1) check("lzb_nib1", bus.nibble, 32'hA);
    end
    check("lzb_lit_count", lit_cnt, LZB ? 2 : 8);

    // Mid-frame reset at index 5 with a load pending.
    step(1, 32'hCAFEBABE, 8'hFF, 0);
    n = 0;
    while (m_idx != 5 && n < 40) begin
      step(0, '0, '0, 0);
      n++;
    end
    check("reach_idx5", m_idx, 5);
    step(0, '0, '0, 1);
    check("mid_rst_an", bus.an, 8'hFF);
    check("mid_rst_nibble", bus.nibble, 0);
    check("mid_rst_blank", bus.blank, 1);
    check("mid_rst_ack", bus.load_ack, 0);
    check("mid_rst_fs", bus.frame_start, 0);
    n    = 0;
    seen = 0;
    while (!seen && n < 100) begin
      step(0, '0, '0, 0);
      n++;
      seen = bus.frame_start;
    end
    check("fs_after_release", n, DIG * (DIV + 1));

    // Random traffic, including loads on the boundary and occasional resets.
    for (int i = 0; i < 1200; i++) begin
      word = $urandom;
      word = word >> (4 * $urandom_range(0, 8));
      step(($urandom_range(0, 7) == 0), word, 8'($urandom), ($urandom_range(0, 299) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/disp_scan.md
DISP_SCAN -- requirements
Module: disp_scan

Interface
REQ-001 Parameter DIV_MAX, default 99999: prescaler terminal count; one digit step every DIV_MAX+1 clocks (1 kHz per digit at 100 MHz).
REQ-002 Parameter DIGITS, default 8: number of scanned digits; legal range 1..8.
REQ-003 clk  input  1  single system clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 value  input  4*DIGITS  display word; digit i = value[4i+3:4i].
REQ-006 digit_en  input  DIGITS  per-digit enable mask, 1 = digit may light.
REQ-007 load  input  1  one-cycle request to stage value and digit_en for display.
REQ-008 load_ack  output  1  one-cycle pulse when staged data becomes the displayed data.
REQ-009 nibble  output  4  hex digit for the downstream 7-segment decoder.
REQ-010 an  output  DIGITS  anode drives, active-low, at most one bit low.
REQ-011 blank  output  1  high when the current digit is dark; downstream forces all segments off.
REQ-012 frame_start  output  1  one-cycle pulse when the scan index returns to 0.

Function
REQ-013 The prescaler SHALL count 0..DIV_MAX, wrap to 0, and assert an internal tick on the cycle its count equals DIV_MAX.
REQ-014 On tick, the scan index SHALL advance by 1, wrapping from DIGITS-1 to 0.
REQ-015 nibble, an, blank and frame_start SHALL be registered and reflect the new index one cycle after the tick.
REQ-016 an SHALL equal ~(1<<idx) when the current digit is lit; otherwise all ones.
REQ-017 A digit SHALL be lit only if its shadow digit_en bit is 1 and it is not blanked per REQ-026; blank = not lit.
REQ-018 nibble SHALL equal the shadow digit at idx whether lit or not.
REQ-019 load SHALL copy value and digit_en into staging registers and set pending; a later load before capture overwrites staging, latest wins.
REQ-020 On the cycle where tick occurs with idx = DIGITS-1 and pending = 1, staging SHALL be copied to shadow, pending cleared, and load_ack pulsed for one cycle.
REQ-021 If load coincides with the capture cycle, the inputs on that cycle SHALL go directly to shadow, with exactly one load_ack.
REQ-022 Without pending, frame boundaries SHALL leave shadow unchanged and load_ack low.
REQ-023 frame_start SHALL pulse exactly once per DIGITS ticks, aligned with the idx-0 outputs.

Reset
REQ-024 While rst_n is low at a clock edge: prescaler 0, idx 0, staging and shadow 0, pending 0, an all ones, nibble 0, blank 1, load_ack 0, frame_start 0.
REQ-025 Reset asserted mid-frame or mid-load SHALL discard pending data; scanning restarts at idx 0 with a full prescaler period after release.

Configuration
REQ-026 With LEADING_ZERO_BLANK_EN defined: digit i (i>0) SHALL be blanked when it and every higher shadow digit are 0; digit 0 is never blanked by this rule. Without the macro: no zero-based blanking; only digit_en darkens digits.

Structure
REQ-027 Package disp_scan_pkg SHALL hold the DIGITS default, the index width constant, and the all-off anode constant.
REQ-028 Prescaler SHALL be a sub-module, scan_prescaler (parameter DIV_MAX, outputs tick).

Verification (DIV_MAX=3, DIGITS=8)
REQ-029 Reset: rst_n low 3 cycles -> an=8'hFF, nibble=0, blank=1, load_ack=0, frame_start=0.
REQ-030 Scan: load 32'h12345678, digit_en 8'hFF -> one load_ack at the frame boundary; then nibble 8, an 8'hFE; 4 clocks later nibble 7, an 8'hFD; continuing through nibble 1, an 8'h7F.
REQ-031 Latest wins: two loads (32'h11111111 then 32'h22222222) before a boundary -> a single load_ack; every digit shows 2.
REQ-032 Mask: digit_en 8'h0F -> digits 4..7 show an=8'hFF, blank=1; digits 0..3 lit.
REQ-033 Blanking, macro defined: value 32'h000000A0 -> digits 0 and 1 lit (nibbles 0, A); digits 2..7 blank. Macro undefined -> all 8 lit.
REQ-034 Mid-frame reset at idx 5 -> next cycle matches REQ-024; frame_start follows 8 ticks after release.
